systolic_array_add_sched: RTL

Sequencer and arbiter for the shared pipelined FP16 adder in the systolic array's partial-sum path. It accepts add requests from `num_req` requesters and picks one by round-robin. It drives the adder's `start`/`count`/operand inputs for the full `add_len`-cycle operation, captures the sum, and returns it to the winning requester with a one-cycle valid pulse. Exactly one addition is in flight at any time.

---
 rtl/systolic_array_add_sched_pkg.sv | 18 +
 rtl/systolic_array_add_sched_rr_arbiter.sv | 39 +++
 rtl/systolic_array_add_sched.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/systolic_array_add_sched_pkg.sv
// systolic_array_add_sched_pkg
//   Shared types and default sizing for the partial-sum adder sequencer.
//   - sched_state_e : sequencer state (IDLE / RUN / RESP)
//   - DEFAULT_*     : default values for the data width, adder latency and
//                     requester count parameters
package systolic_array_add_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } sched_state_e;

  localparam int DEFAULT_DATA_W  = 16;
  localparam int DEFAULT_ADD_LEN = 3;
  localparam int DEFAULT_NUM_REQ = 4;

endpackage

// File: rtl/systolic_array_add_sched_rr_arbiter.sv
// rr_arbiter
//   Purely combinational rotating-priority pick. The search starts at index
//   `ptr` and wraps around, so `ptr` has the highest priority and `ptr-1` the
//   lowest. The pointer itself is owned by the instantiating module.
//   Ports:
//     req   in  num_req          request vector
//     ptr   in  $clog2(num_req)  index with highest priority
//     grant out num_req          one-hot winner (all zero when req is zero)
module rr_arbiter
  import systolic_array_add_sched_pkg::*;
#(
  parameter int num_req = DEFAULT_NUM_REQ
) (
  input  logic [num_req-1:0]         req,
  input  logic [$clog2(num_req)-1:0] ptr,
  output logic [num_req-1:0]         grant
);

  localparam int ptr_w = $clog2(num_req);

  logic [ptr_w-1:0] idx;
  logic             found;

  // Walk the requesters in priority order starting at the pointer; the first
  // asserted request wins and blocks everyone after it.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < num_req; k++) begin
      idx = ptr_w'((int'(ptr) + k) % num_req);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/systolic_array_add_sched.sv
// systolic_array_add_sched
//   Sequencer/arbiter in front of the shared pipelined FP16 adder of the
//   systolic array partial-sum path. One requester is granted at a time; the
//   adder is driven for add_len cycles, its output is captured and handed back
//   to the winner with a one-cycle valid pulse. Only one addition is ever in
//   flight.
//
//   Build option:
//     SA_ADD_SCHED_FIXED_PRIO_EN  defined   -> fixed priority, lowest index
//                                              wins, no pointer register
//                                 undefined -> round-robin (default)
//
//   Ports:
//     CLK, nRST     clock (rising edge) / asynchronous active-low reset
//     req           per-requester request
//     op1, op2      per-requester operands
//     gnt           one-hot grant pulse (first RUN cycle)
//     resp_valid    one-hot result-valid pulse (RESP cycle)
//     resp_data     shared result bus, holds until the next capture
//     busy          high while the adder is running
//     add_start     adder start (first RUN cycle only)
//     add_count     adder step counter 0..add_len-1
//     add_in1/2     adder operands, stable through RUN
//     add_out       adder result
module systolic_array_add_sched
  import systolic_array_add_sched_pkg::*;
#(
  parameter int data_w  = DEFAULT_DATA_W,
  parameter int add_len = DEFAULT_ADD_LEN,
  parameter int num_req = DEFAULT_NUM_REQ
) (
  input  logic                             CLK,
  input  logic                             nRST,
  input  logic [num_req-1:0]               req,
  input  logic [num_req-1:0][data_w-1:0]   op1,
  input  logic [num_req-1:0][data_w-1:0]   op2,
  output logic [num_req-1:0]               gnt,
  output logic [num_req-1:0]               resp_valid,
  output logic [data_w-1:0]                resp_data,
  output logic                             busy,
  output logic                             add_start,
  output logic [$clog2(add_len)-1:0]       add_count,
  output logic [data_w-1:0]                add_in1,
  output logic [data_w-1:0]                add_in2,
  input  logic [data_w-1:0]                add_out
);

  localparam int cnt_w = $clog2(add_len);
  localparam int ptr_w = $clog2(num_req);

  sched_state_e       state;
  sched_state_e       next_state;
  logic [ptr_w-1:0]   arb_ptr;
  logic [ptr_w-1:0]   win_idx;
  logic [num_req-1:0] win;
  logic [num_req-1:0] owner;
  logic               grant_now;
  logic               last_cnt;

  assign last_cnt = (add_count == cnt_w'(add_len - 1));

`ifdef SA_ADD_SCHED_FIXED_PRIO_EN
  // Searching from index 0 every time turns the rotating arbiter into a
  // fixed lowest-index-wins priority encoder.
  assign arb_ptr = '0;
`else
  logic [ptr_w-1:0] rr_ptr;

  // The pointer moves just past the last winner, so that winner drops to the
  // lowest priority for the next arbitration round.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr <= '0;
    end else if (grant_now) begin
      rr_ptr <= (win_idx == ptr_w'(num_req - 1)) ? '0 : win_idx + ptr_w'(1);
    end
  end

  assign arb_ptr = rr_ptr;
`endif

  rr_arbiter #(
    .num_req(num_req)
  ) u_arb (
    .req  (req),
    .ptr  (arb_ptr),
    .grant(win)
  );

  // Binary index of the one-hot winner, used to steer the operand mux and
  // the pointer update.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < num_req; i++) begin
      if (win[i]) begin
        win_idx = ptr_w'(i);
      end
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. RESP lasts exactly one cycle and can chain straight
  // into the next RUN, which is what gives one op every add_len+1 cycles.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|req)    next_state = RUN;
      RUN:     if (last_cnt) next_state = RESP;
      RESP:    next_state = (|req) ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Decoded outputs. The counter is only ever zero in the first RUN cycle,
  // so that doubles as the adder start strobe.
  always_comb begin
    busy      = (state == RUN);
    add_start = (state == RUN) && (add_count == '0);
    grant_now = ((state == IDLE) || (state == RESP)) && (|req);
  end

  // Datapath: latch the winner's operands at grant, step the counter while
  // running, and capture the adder output on the last step. `owner` remembers
  // who was granted so the result can be routed back.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      gnt        <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      add_count  <= '0;
      add_in1    <= '0;
      add_in2    <= '0;
      owner      <= '0;
    end else begin
      gnt        <= '0;
      resp_valid <= '0;
      if (grant_now) begin
        gnt       <= win;
        owner     <= win;
        add_in1   <= op1[win_idx];
        add_in2   <= op2[win_idx];
        add_count <= '0;
      end else if (state == RUN) begin
        if (last_cnt) begin
          resp_data  <= add_out;
          resp_valid <= owner;
          add_count  <= '0;
        end else begin
          add_count <= add_count + cnt_w'(1);
        end
      end
    end
  end

endmodule
